// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the fetch sequencer.
//   fetch_state_e   - sequencer FSM state (run / halted)
//   DEFAULT_HALT_OP - default instruction encoding that halts the core
//   next_pc()       - next-pc selection: jump, then relative branch, then +1
package fetch_pkg;

   typedef enum logic {
      StRun,
      StHalted
   } fetch_state_e;

   localparam logic [8:0] DEFAULT_HALT_OP = 9'h1FF;

   // Widest PC the helper supports; callers zero-extend in and truncate out,
   // which gives the modulo-2**AW wrap for relative branches.
   localparam int unsigned MAX_AW = 32;

   function automatic logic [MAX_AW-1:0] next_pc(input logic [MAX_AW-1:0] pc,
                                                 input logic              jump,
                                                 input logic              branch,
                                                 input logic [MAX_AW-1:0] target);
      if (jump) begin
         return target;
      end else if (branch) begin
         return pc + target;
      end else begin
         return pc + MAX_AW'(1);
      end
   endfunction

endpackage

// File: rtl/target_lut.sv
// target_lut: programmable jump/branch target table.
//   CLK   - clock, posedge
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - combinational read data (old value on same-cycle write)
// Contents have no reset so they survive a sequencer restart.
module target_lut #(
   parameter int unsigned AW = 10,
   parameter int unsigned TW = 4
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [TW-1:0] waddr,
   input  logic [AW-1:0] wdata,
   input  logic [TW-1:0] raddr,
   output logic [AW-1:0] rdata
);

   logic [AW-1:0] mem [2**TW];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: program counter, jump/branch via target LUT, stall, halt
// detection, cycle and retired-instruction counters.
//   CLK        - clock, posedge
//   start      - asynchronous active-high reset (LUT not cleared)
//   inst_in    - instruction at pc from ROM
//   stall      - hold pc this cycle
//   jump_en    - pc <= lut[tgt_idx]
//   branch_en  - pc <= pc + lut[tgt_idx]
//   tgt_idx    - LUT index for jump/branch
//   lut_we, lut_waddr, lut_wdata - LUT write port (active in any state)
//   pc         - program counter / ROM address
//   halt       - sticky halted flag (registered)
//   cycle_ct   - saturating count of RUN cycles
//   retired_ct - saturating count of retired instructions
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int unsigned    AW      = 10,
   parameter int unsigned    IW      = 9,
   parameter int unsigned    TW      = 4,
   parameter int unsigned    CW      = 16,
   parameter logic [IW-1:0]  HALT_OP = DEFAULT_HALT_OP
) (
   input  logic          CLK,
   input  logic          start,
   input  logic [IW-1:0] inst_in,
   input  logic          stall,
   input  logic          jump_en,
   input  logic          branch_en,
   input  logic [TW-1:0] tgt_idx,
   input  logic          lut_we,
   input  logic [TW-1:0] lut_waddr,
   input  logic [AW-1:0] lut_wdata,
   output logic [AW-1:0] pc,
   output logic          halt,
   output logic [CW-1:0] cycle_ct,
   output logic [CW-1:0] retired_ct
);

   localparam logic [AW-1:0] PC_MAX = '1;
   localparam logic [CW-1:0] CT_MAX = '1;

   fetch_state_e  state;
   logic [AW-1:0] lut_rdata;
   logic [AW-1:0] pc_next;
   logic          seq_end;

   target_lut #(
      .AW (AW),
      .TW (TW)
   ) u_target_lut (
      .CLK   (CLK),
      .we    (lut_we),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (tgt_idx),
      .rdata (lut_rdata)
   );

   assign pc_next = AW'(next_pc(MAX_AW'(pc), jump_en, branch_en, MAX_AW'(lut_rdata)));

   // Sequential fetch off the top of the address space halts instead of wrapping.
   assign seq_end = !jump_en && !branch_en && (pc == PC_MAX);

   always_ff @(posedge CLK or posedge start) begin
      if (start) begin
         state      <= StRun;
         pc         <= '0;
         halt       <= 1'b0;
         cycle_ct   <= '0;
         retired_ct <= '0;
      end else if (state == StRun) begin
         if (cycle_ct != CT_MAX) begin
            cycle_ct <= cycle_ct + CW'(1);
         end
         if (!stall) begin
            // The halting instruction and the final sequential fetch both retire.
            if (retired_ct != CT_MAX) begin
               retired_ct <= retired_ct + CW'(1);
            end
            if (inst_in == HALT_OP || seq_end) begin
               state <= StHalted;
               halt  <= 1'b1;
            end else begin
               pc <= pc_next;
            end
         end
      end
   end

endmodule
